// File: rtl/pcs_rx_parser_if.sv
// Symbol-stream / GMII-receive bundle for the PCS receive parser.
// Parser side uses the slave modport; the symbol source uses master.
interface pcs_rx_parser_if;
    logic [7:0]  rx_byte;
    logic        rx_is_k;
    logic        rx_code_err;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        sync_ok;
    logic [15:0] lacr_rx;
    logic        lacr_match;
    logic        rx_mode_c;
    logic        rx_idle;

    modport master (
        output rx_byte, rx_is_k, rx_code_err,
        input  RXD, RX_DV, RX_ER, sync_ok, lacr_rx, lacr_match, rx_mode_c, rx_idle
    );

    modport slave (
        input  rx_byte, rx_is_k, rx_code_err,
        output RXD, RX_DV, RX_ER, sync_ok, lacr_rx, lacr_match, rx_mode_c, rx_idle
    );
endinterface

// File: rtl/pcs_rx_parser.sv
// 1000BASE-X PCS receive: comma sync FSM, /C/ and /I/ ordered-set decode, GMII frame recovery.
// Latency 2 clk from symbol to RXD/RX_DV/RX_ER; no backpressure, one symbol accepted every clk.
module pcs_rx_parser #(
    parameter int MATCH_COUNT = 3,
    parameter int ACQ_COUNT   = 3
) (
    input  logic           clk,
    input  logic           rst,
    pcs_rx_parser_if.slave bus
);
    localparam logic [7:0] K28_5    = 8'hBC;
    localparam logic [7:0] D21_5    = 8'hB5;
    localparam logic [7:0] D2_2     = 8'h42;
    localparam logic [7:0] D5_6     = 8'hC5;
    localparam logic [7:0] D16_2    = 8'h50;
    localparam logic [7:0] K_START  = 8'hFB;
    localparam logic [7:0] K_TERM   = 8'hFD;
    localparam logic [7:0] PREAMBLE = 8'h55;

    typedef enum logic [1:0] {SY_LOS, SY_ACQ, SY_SYNC} sync_st_t;
    typedef enum logic [1:0] {RS_IDLE, RS_CFG, RS_DATA, RS_ERR} rx_st_t;

    sync_st_t    r_sync_st, w_sync_nxt;
    rx_st_t      r_rx_st, w_rx_nxt;
    logic        r_phase_odd, r_prev_comma;
    logic [3:0]  r_acq_cnt, w_acq_nxt, r_err_cnt, w_err_nxt;
    logic [1:0]  r_good_cnt, w_good_nxt;
    logic        r_cfg_idx, w_cfg_idx_nxt;
    logic [7:0]  r_cfg_lo, w_cfg_lo_nxt;
    logic        w_cfg_done, w_idle_hit;
    logic [15:0] r_lacr, w_new_lacr;
    logic [2:0]  r_match_cnt;
    logic        r_mode_c, r_idle;
    logic [7:0]  w_s1_dat, r_s1_dat, r_rxd;
    logic        w_s1_dv, w_s1_er, r_s1_dv, r_s1_er, r_dv, r_er;
    logic        w_comma, w_sync_ok, w_dchar, w_cfg_code, w_idle_code, w_bad;

    assign w_comma     = bus.rx_is_k && (bus.rx_byte == K28_5);
    assign w_sync_ok   = (r_sync_st == SY_SYNC);
    assign w_dchar     = !bus.rx_is_k && !bus.rx_code_err;
    assign w_cfg_code  = r_prev_comma && w_dchar && (bus.rx_byte == D21_5 || bus.rx_byte == D2_2);
    assign w_idle_code = r_prev_comma && w_dchar && (bus.rx_byte == D5_6 || bus.rx_byte == D16_2);
    // r_phase_odd holds the phase this symbol would have without a comma forcing it even
    assign w_bad       = bus.rx_code_err || (w_comma && r_phase_odd);
    assign w_new_lacr  = {bus.rx_byte, r_cfg_lo};

    always_comb begin
        w_sync_nxt = r_sync_st;
        w_acq_nxt  = r_acq_cnt;
        w_err_nxt  = r_err_cnt;
        w_good_nxt = r_good_cnt;
        case (r_sync_st)
            SY_LOS: begin
                if (w_comma && !bus.rx_code_err) begin
                    w_sync_nxt = SY_ACQ;
                    w_acq_nxt  = 4'd1;
                end
            end
            SY_ACQ: begin
                if (bus.rx_code_err) begin
                    w_sync_nxt = SY_LOS;
                    w_acq_nxt  = 4'd0;
                end else if (w_comma && r_phase_odd) begin
                    w_acq_nxt = 4'd1;
                end else if (w_comma) begin
                    if (r_acq_cnt + 4'd1 == 4'(ACQ_COUNT)) begin
                        w_sync_nxt = SY_SYNC;
                        w_acq_nxt  = 4'd0;
                        w_err_nxt  = 4'd0;
                        w_good_nxt = 2'd0;
                    end else begin
                        w_acq_nxt = r_acq_cnt + 4'd1;
                    end
                end
            end
            SY_SYNC: begin
                if (w_bad) begin
                    w_good_nxt = 2'd0;
                    if (r_err_cnt + 4'd1 == 4'd4) begin
                        w_sync_nxt = SY_LOS;
                        w_err_nxt  = 4'd0;
                    end else begin
                        w_err_nxt = r_err_cnt + 4'd1;
                    end
                end else if (r_good_cnt == 2'd3) begin
                    w_good_nxt = 2'd0;
                    if (r_err_cnt != 4'd0) w_err_nxt = r_err_cnt - 4'd1;
                end else begin
                    w_good_nxt = r_good_cnt + 2'd1;
                end
            end
            default: w_sync_nxt = SY_LOS;
        endcase
    end

    always_comb begin
        w_rx_nxt      = r_rx_st;
        w_s1_dat      = 8'h00;
        w_s1_dv       = 1'b0;
        w_s1_er       = 1'b0;
        w_cfg_idx_nxt = 1'b0;
        w_cfg_lo_nxt  = r_cfg_lo;
        w_cfg_done    = 1'b0;
        w_idle_hit    = 1'b0;
        if (!w_sync_ok) begin
            w_rx_nxt = RS_IDLE;
            if (r_rx_st == RS_DATA || r_rx_st == RS_ERR) begin
                w_s1_dat = bus.rx_byte;
                w_s1_dv  = 1'b1;
                w_s1_er  = 1'b1;
            end
        end else begin
            case (r_rx_st)
                RS_IDLE: begin
                    if (w_cfg_code) begin
                        w_rx_nxt = RS_CFG;
                    end else if (w_idle_code) begin
                        w_idle_hit = 1'b1;
                    end else if (bus.rx_is_k && bus.rx_byte == K_START && !r_phase_odd) begin
                        w_rx_nxt = RS_DATA;
                        w_s1_dat = PREAMBLE;
                        w_s1_dv  = 1'b1;
                    end
                end
                RS_CFG: begin
                    if (bus.rx_is_k) begin
                        w_rx_nxt = RS_IDLE;
                    end else if (!r_cfg_idx) begin
                        w_cfg_lo_nxt  = bus.rx_byte;
                        w_cfg_idx_nxt = 1'b1;
                    end else begin
                        w_cfg_done = 1'b1;
                        w_rx_nxt   = RS_IDLE;
                    end
                end
                RS_DATA: begin
                    w_s1_dat = bus.rx_byte;
                    w_s1_dv  = 1'b1;
                    if (w_comma) begin
                        // truncated frame: flag it, then the comma starts a new ordered set
                        w_s1_er  = 1'b1;
                        w_rx_nxt = RS_IDLE;
                    end else if (bus.rx_code_err || (bus.rx_is_k && bus.rx_byte != K_TERM)) begin
                        w_s1_er = 1'b1;
                    end else if (bus.rx_is_k) begin
                        w_s1_dat = 8'h00;
                        w_s1_dv  = 1'b0;
                        w_rx_nxt = RS_IDLE;
                    end
                end
                default: w_rx_nxt = RS_IDLE;
            endcase
            if (w_sync_nxt != SY_SYNC && w_rx_nxt == RS_DATA) w_rx_nxt = RS_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_st <= SY_LOS;
            r_rx_st   <= RS_IDLE;
        end else begin
            r_sync_st <= w_sync_nxt;
            r_rx_st   <= w_rx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_odd  <= 1'b0;
            r_prev_comma <= 1'b0;
            r_acq_cnt    <= 4'd0;
            r_err_cnt    <= 4'd0;
            r_good_cnt   <= 2'd0;
            r_cfg_idx    <= 1'b0;
            r_cfg_lo     <= 8'h00;
            r_lacr       <= 16'h0000;
            r_match_cnt  <= 3'd0;
            r_mode_c     <= 1'b0;
            r_idle       <= 1'b0;
            r_s1_dat     <= 8'h00;
            r_s1_dv      <= 1'b0;
            r_s1_er      <= 1'b0;
            r_rxd        <= 8'h00;
            r_dv         <= 1'b0;
            r_er         <= 1'b0;
        end else begin
            r_phase_odd  <= w_comma ? 1'b1 : !r_phase_odd;
            r_prev_comma <= w_comma;
            r_acq_cnt    <= w_acq_nxt;
            r_err_cnt    <= w_err_nxt;
            r_good_cnt   <= w_good_nxt;
            r_cfg_idx    <= w_cfg_idx_nxt;
            r_cfg_lo     <= w_cfg_lo_nxt;
            r_idle       <= w_idle_hit;
            if (w_cfg_done) begin
                r_lacr   <= w_new_lacr;
                r_mode_c <= 1'b1;
                if (w_new_lacr != r_lacr) begin
                    r_match_cnt <= 3'd1;
                end else if (r_match_cnt != 3'(MATCH_COUNT)) begin
                    r_match_cnt <= r_match_cnt + 3'd1;
                end
            end else if (w_idle_hit) begin
                r_mode_c    <= 1'b0;
                r_match_cnt <= 3'd0;
            end
            r_s1_dat <= w_s1_dat;
            r_s1_dv  <= w_s1_dv;
            r_s1_er  <= w_s1_er;
            r_rxd    <= r_s1_dat;
            r_dv     <= r_s1_dv;
            r_er     <= r_s1_er;
        end
    end

    assign bus.RXD        = r_rxd;
    assign bus.RX_DV      = r_dv;
    assign bus.RX_ER      = r_er;
    assign bus.sync_ok    = w_sync_ok;
    assign bus.lacr_rx    = r_lacr;
    assign bus.lacr_match = (r_match_cnt == 3'(MATCH_COUNT));
    assign bus.rx_mode_c  = r_mode_c;
    assign bus.rx_idle    = r_idle;
endmodule

// File: tb/tb_pcs_rx_parser.sv
// Directed bench for pcs_rx_parser: vector table for sync, /C/, /I/ and frames, plus hand sequences.
module tb_pcs_rx_parser;
    localparam logic K = 1'b1;
    localparam logic D = 1'b0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcs_rx_parser_if bus();

    pcs_rx_parser #(.MATCH_COUNT(3), .ACQ_COUNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        k;
        logic [7:0]  b;
        logic        e;
        logic [7:0]  rxd;
        logic        dv;
        logic        er;
        logic        sy;
        logic        idl;
        logic        mc;
        logic [15:0] lacr;
        logic        mt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t v(logic k, logic [7:0] b, logic e, logic [7:0] rxd, logic dv, logic er,
                               logic sy, logic idl, logic mc, logic [15:0] lacr, logic mt);
        vec_t r;
        r.k = k; r.b = b; r.e = e; r.rxd = rxd; r.dv = dv; r.er = er;
        r.sy = sy; r.idl = idl; r.mc = mc; r.lacr = lacr; r.mt = mt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_o(input string t, input logic [7:0] rxd, input logic dv, input logic er);
        chk({t, " RXD"}, 16'(bus.RXD), 16'(rxd));
        chk({t, " RX_DV"}, 16'(bus.RX_DV), 16'(dv));
        chk({t, " RX_ER"}, 16'(bus.RX_ER), 16'(er));
    endtask

    // outputs are sampled 1 ns after the edge that consumed the symbol
    task automatic send(input logic k, input logic [7:0] b, input logic e);
        bus.rx_is_k     = k;
        bus.rx_byte     = b;
        bus.rx_code_err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic acquire(input string t);
        for (int i = 0; i < 4; i++) begin
            send(K, 8'hBC, 0);
            send(D, 8'h50, 0);
        end
        chk({t, " sync_ok"}, 16'(bus.sync_ok), 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_byte = 8'h00; bus.rx_is_k = 1'b0; bus.rx_code_err = 1'b0;

        // sync acquisition on /I2/
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 0,0,0,16'h0000,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 0,0,0,16'h0000,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 0,0,0,16'h0000,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 0,0,0,16'h0000,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,0,16'h0000,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 1,1,0,16'h0000,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,0,16'h0000,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 1,1,0,16'h0000,0));
        // /C1/ A0,01 three times, then 41,01
        for (int n = 0; n < 3; n++) begin
            tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,(n>0),(n>0)?16'h01A0:16'h0000,(n==2)?1'b0:1'b0));
            tbl.push_back(v(D,8'hB5,0, 8'h00,0,0, 1,0,(n>0),(n>0)?16'h01A0:16'h0000,0));
            tbl.push_back(v(D,8'hA0,0, 8'h00,0,0, 1,0,(n>0),(n>0)?16'h01A0:16'h0000,0));
            tbl.push_back(v(D,8'h01,0, 8'h00,0,0, 1,0,1,16'h01A0,(n==2)));
        end
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,1,16'h01A0,1));
        tbl.push_back(v(D,8'hB5,0, 8'h00,0,0, 1,0,1,16'h01A0,1));
        tbl.push_back(v(D,8'h41,0, 8'h00,0,0, 1,0,1,16'h01A0,1));
        tbl.push_back(v(D,8'h01,0, 8'h00,0,0, 1,0,1,16'h0141,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,1,16'h0141,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 1,1,0,16'h0141,0));
        // clean frame /S/ 11 22 33 /T/ /R/ /I2/
        tbl.push_back(v(K,8'hFB,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'h11,0, 8'h55,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'h22,0, 8'h11,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'h33,0, 8'h22,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hFD,0, 8'h33,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hF7,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 1,1,0,16'h0141,0));
        // frame with a code error on the 2nd data byte
        tbl.push_back(v(K,8'hFB,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'hAA,0, 8'h55,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'hBB,1, 8'hAA,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'hCC,0, 8'hBB,1,1, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hFD,0, 8'hCC,1,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hF7,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(K,8'hBC,0, 8'h00,0,0, 1,0,0,16'h0141,0));
        tbl.push_back(v(D,8'h50,0, 8'h00,0,0, 1,1,0,16'h0141,0));

        send(D, 8'h00, 0);
        send(D, 8'h00, 0);
        chk_o("reset", 8'h00, 0, 0);
        chk("reset sync_ok", 16'(bus.sync_ok), 16'd0);
        chk("reset lacr_rx", bus.lacr_rx, 16'h0000);
        chk("reset lacr_match", 16'(bus.lacr_match), 16'd0);
        chk("reset rx_mode_c", 16'(bus.rx_mode_c), 16'd0);
        chk("reset rx_idle", 16'(bus.rx_idle), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("row%0d", i);
            send(tbl[i].k, tbl[i].b, tbl[i].e);
            chk_o(t, tbl[i].rxd, tbl[i].dv, tbl[i].er);
            chk({t, " sync_ok"}, 16'(bus.sync_ok), 16'(tbl[i].sy));
            chk({t, " rx_idle"}, 16'(bus.rx_idle), 16'(tbl[i].idl));
            chk({t, " rx_mode_c"}, 16'(bus.rx_mode_c), 16'(tbl[i].mc));
            chk({t, " lacr_rx"}, bus.lacr_rx, tbl[i].lacr);
            chk({t, " lacr_match"}, 16'(bus.lacr_match), 16'(tbl[i].mt));
        end

        // four code errors mid-frame: sync lost, frame closed with an error slot
        send(K, 8'hFB, 0);
        send(D, 8'h11, 0); chk_o("los s1", 8'h55, 1, 0);
        send(D, 8'h22, 1); chk_o("los s2", 8'h11, 1, 0);
        send(D, 8'h33, 1); chk_o("los s3", 8'h22, 1, 1);
        send(D, 8'h44, 1); chk("los s4 sync_ok", 16'(bus.sync_ok), 16'd1);
        send(D, 8'h55, 1); chk("los s5 sync_ok", 16'(bus.sync_ok), 16'd0);
        send(D, 8'h66, 0); chk("los s6 RX_ER", 16'(bus.RX_ER), 16'd1);
        send(D, 8'h77, 0); chk("los s7 RX_DV", 16'(bus.RX_DV), 16'd1);
        chk("los s7 RX_ER", 16'(bus.RX_ER), 16'd1);
        send(D, 8'h88, 0); chk_o("los s8", 8'h00, 0, 0);
        send(D, 8'h99, 0); chk_o("los s9", 8'h00, 0, 0);

        // /S/ at odd phase ignored; code error outside a frame gives no RX_ER
        acquire("reacq1");
        send(D, 8'h00, 0);
        send(K, 8'hFB, 0);
        send(D, 8'h11, 1); chk_o("odd s slot", 8'h00, 0, 0);
        send(D, 8'h22, 0); chk_o("idle err slot", 8'h00, 0, 0);
        send(D, 8'h33, 0); chk_o("odd after1", 8'h00, 0, 0);
        send(D, 8'h44, 0); chk_o("odd after2", 8'h00, 0, 0);

        // comma inside a frame truncates it and is decoded as an ordered set
        send(K, 8'hFB, 0);
        send(D, 8'h01, 0); chk_o("trunc s", 8'h55, 1, 0);
        send(K, 8'hBC, 0); chk_o("trunc d", 8'h01, 1, 0);
        send(D, 8'h50, 0); chk("trunc comma RX_DV", 16'(bus.RX_DV), 16'd1);
        chk("trunc comma RX_ER", 16'(bus.RX_ER), 16'd1);
        chk("trunc rx_idle", 16'(bus.rx_idle), 16'd1);
        send(K, 8'hBC, 0); chk_o("trunc after", 8'h00, 0, 0);
        send(D, 8'h50, 0);

        // reset during frame data
        send(K, 8'hFB, 0);
        send(D, 8'hAA, 0);
        send(D, 8'hBB, 0);
        rst = 1'b1;
        send(D, 8'hCC, 0);
        chk_o("midrst", 8'h00, 0, 0);
        chk("midrst sync_ok", 16'(bus.sync_ok), 16'd0);
        chk("midrst lacr_rx", bus.lacr_rx, 16'h0000);
        chk("midrst lacr_match", 16'(bus.lacr_match), 16'd0);
        chk("midrst rx_mode_c", 16'(bus.rx_mode_c), 16'd0);
        chk("midrst rx_idle", 16'(bus.rx_idle), 16'd0);
        rst = 1'b0;
        send(D, 8'hDD, 0); chk_o("post rst1", 8'h00, 0, 0);
        send(D, 8'hEE, 0); chk_o("post rst2", 8'h00, 0, 0);
        send(K, 8'hFD, 0); chk_o("post rst3", 8'h00, 0, 0);
        send(K, 8'hBC, 0); chk("post rst4 RX_DV", 16'(bus.RX_DV), 16'd0);
        send(D, 8'h50, 0); chk("post rst5 sync_ok", 16'(bus.sync_ok), 16'd0);
        acquire("reacq2");
        send(K, 8'hFB, 0);
        send(D, 8'h12, 0); chk_o("new frame s", 8'h55, 1, 0);
        send(K, 8'hFD, 0); chk_o("new frame d", 8'h12, 1, 0);
        send(K, 8'hF7, 0); chk_o("new frame t", 8'h00, 0, 0);
        send(K, 8'hBC, 0); chk_o("new frame r", 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pcs_rx_parser.md
PCS_RX_PARSER -- requirements
Module: pcs_rx_parser

Interface
REQ-001 Parameter MATCH_COUNT, default 3: consecutive identical /C/ ordered sets required before lacr_match asserts.
REQ-002 Parameter ACQ_COUNT, default 3: consecutive aligned commas required to acquire sync.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_byte  in  8  decoded 8b/10b symbol, one per clk.
REQ-006 rx_is_k  in  1  rx_byte is a K code.
REQ-007 rx_code_err  in  1  decoder disparity/code violation on this symbol.
REQ-008 RXD  out  8  GMII receive data.
REQ-009 RX_DV  out  1  GMII receive data valid.
REQ-010 RX_ER  out  1  GMII receive error.
REQ-011 sync_ok  out  1  symbol/ordered-set alignment acquired.
REQ-012 lacr_rx  out  16  last received /C/ config register, {byte3, byte2}.
REQ-013 lacr_match  out  1  MATCH_COUNT consecutive identical /C/ values received.
REQ-014 rx_mode_c  out  1  1 = last ordered set was /C/, 0 = /I/.
REQ-015 rx_idle  out  1  pulses one cycle per complete /I1/ or /I2/ received.

Function
REQ-016 Codes: K28.5=BC, /C1/=BC,B5, /C2/=BC,42, /I1/=BC,C5, /I2/=BC,50, /S/=K FB, /T/=K FD, /R/=K F7, /V/=K FE; /C/ carries two config bytes after its second symbol.
REQ-017 Even/odd phase toggles every cycle; a K28.5 forces even phase on that cycle.
REQ-018 Sync FSM states: LOS, ACQ, SYNC. LOS->ACQ on any K28.5; ACQ counts K28.5 at even phase spaced by even gaps, any rx_code_err returns to LOS; ACQ->SYNC when count reaches ACQ_COUNT.
REQ-019 In SYNC: 4-bit error counter +1 on rx_code_err or K28.5 at odd phase; -1 (floor 0) after every 4 consecutive clean symbols; counter reaching 4 -> LOS.
REQ-020 sync_ok = 1 exactly in SYNC.
REQ-021 Receive FSM states: IDLE, CFG, DATA, ERR; active only when sync_ok, forced to IDLE otherwise.
REQ-022 IDLE: K28.5 + D21.5/D2.2 -> CFG; /S/ at even phase -> DATA; K28.5 + D5.6/D16.2 -> rx_idle pulse, rx_mode_c=0.
REQ-023 CFG: capture two bytes, low byte first; update lacr_rx once complete; return to IDLE; set rx_mode_c=1.
REQ-024 lacr_match: 3-bit counter increments when a new /C/ equals previous lacr_rx, resets to 1 on mismatch, saturates at MATCH_COUNT; lacr_match = (counter == MATCH_COUNT); any /I/ clears counter.
REQ-025 Latency: fixed 2 clk from rx_byte to RXD/RX_DV/RX_ER.
REQ-026 /S/ emitted as RXD=55, RX_DV=1 (preamble substitution); subsequent data bytes pass with RX_DV=1, RX_ER=0.
REQ-027 /T/ in DATA: RX_DV=0 at its output slot; following /R/ symbols produce RX_DV=0, RX_ER=0; FSM -> IDLE.
REQ-028 In DATA, rx_code_err, /V/, or any K other than /T/ -> RX_DV=1, RX_ER=1, RXD=rx_byte for that slot; remain in DATA.
REQ-029 K28.5 inside DATA (truncated frame): RX_DV=1, RX_ER=1 one slot, then RX_DV=0; FSM processes the comma as in IDLE.
REQ-030 /S/ at odd phase ignored; rx_code_err outside DATA produces no RX_ER.
REQ-031 sync loss mid-frame: RX_DV=1, RX_ER=1 on next output slot, then RX_DV=0.
REQ-032 Outside DATA: RXD=00, RX_DV=0, RX_ER=0.

Reset
REQ-033 rst asserted: next edge RXD=00, RX_DV=0, RX_ER=0, sync_ok=0, lacr_rx=0000, lacr_match=0, rx_mode_c=0, rx_idle=0, all counters 0, sync FSM LOS, receive FSM IDLE; pipeline flushed.
REQ-034 rst mid-frame: no partial frame bytes emitted after deassertion; reacquisition required.

Verification
REQ-035 Reset, then repeat /I2/ (BC,50) -> sync_ok=1 after 3rd aligned comma; rx_idle pulses every 2 cycles.
REQ-036 /C1/ BC,B5,A0,01 x3 -> lacr_rx=01A0, lacr_match=1 after 3rd set, rx_mode_c=1; change to 41,01 -> lacr_match=0, lacr_rx=0141.
REQ-037 In SYNC: /S/,11,22,33,/T/,/R/,/I2/ -> two cycles later RXD=55,11,22,33 with RX_DV=1, RX_ER=0, then RX_DV=0.
REQ-038 Frame with rx_code_err on 2nd data byte -> RX_ER=1 on that slot only, RX_DV stays 1 until /T/.
REQ-039 In SYNC, 4 rx_code_err within 8 symbols -> sync_ok=0; active frame ends with RX_ER=1 slot then RX_DV=0.
REQ-040 rst pulsed during frame data -> all outputs 0 next cycle; no RX_DV until sync reacquired and new /S/.
